// File: rtl/spiroc_emu_pkg.sv
// Shared types and helpers for the SPIROC2b readout emulator.
package spiroc_emu_pkg;

    localparam int WORD_W_DEF = 16;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_END   = 2'd2
    } emu_state_e;

    // Ceiling log2; CLOG2(1) = 0, CLOG2(64) = 6.
    function automatic int CLOG2(input int n);
        int r;
        r = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < n) r = i + 1;
        end
        return r;
    endfunction

    // Width of a counter that runs 0..n-1 (never narrower than one bit).
    function automatic int CTR_W(input int n);
        return (n <= 2) ? 1 : CLOG2(n);
    endfunction

endpackage

// File: rtl/spiroc_readout_emulator_if.sv
// Firmware-side and serial-side signal bundle of the readout emulator.
// Handshake: a word is taken on every clk edge where wr_en=1 and full=0;
// wr_en while full drops the word and sets the sticky overflow flag.
// start_readout is a level request: its rising edge opens a frame, and
// holding it high lets queued words stream back-to-back.
interface spiroc_readout_emulator_if
    import spiroc_emu_pkg::*;
#(
    parameter int WORD_W     = WORD_W_DEF,
    parameter int FIFO_DEPTH = 64
) ();

    localparam int CNT_W = CLOG2(FIFO_DEPTH) + 1;

    logic              wr_en;
    logic [WORD_W-1:0] wr_data;
    logic              full;
    logic [CNT_W-1:0]  count;
    logic              overflow;
    logic              start_readout;
    logic              dout_b;
    logic              transmit_on_b;
    logic              end_readout;
    logic              busy;
    logic [1:0]        dbg_state;

    modport master (
        output wr_en, wr_data, start_readout,
        input  full, count, overflow, dout_b, transmit_on_b, end_readout, busy, dbg_state
    );

    modport slave (
        input  wr_en, wr_data, start_readout,
        output full, count, overflow, dout_b, transmit_on_b, end_readout, busy, dbg_state
    );

endinterface

// File: rtl/emu_word_fifo.sv
// Synchronous show-ahead word queue: head is valid whenever not empty.
module emu_word_fifo
    import spiroc_emu_pkg::*;
#(
    parameter int WORD_W = WORD_W_DEF,
    parameter int DEPTH  = 64,
    localparam int AW    = CLOG2(DEPTH),
    localparam int CW    = AW + 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              i_push,
    input  logic [WORD_W-1:0] i_data,
    input  logic              i_pop,
    output logic [WORD_W-1:0] o_head,
    output logic              o_empty,
    output logic              o_full,
    output logic [CW-1:0]     o_count,
    output logic              o_overflow
);

    logic [WORD_W-1:0] r_mem [DEPTH];
    logic [AW-1:0]     r_wr_ptr;
    logic [AW-1:0]     r_rd_ptr;
    logic [CW-1:0]     r_count;
    logic              r_full;
    logic              r_empty;
    logic              r_overflow;

    logic              w_push;
    logic              w_pop;
    logic [CW-1:0]     w_count_nxt;

    // A push while full is dropped even if a pop happens the same cycle.
    assign w_push = i_push & ~r_full;
    assign w_pop  = i_pop & ~r_empty;

    // Next occupancy; simultaneous push and pop leave it unchanged.
    always_comb begin
        w_count_nxt = r_count;
        case ({w_push, w_pop})
            2'b10:   w_count_nxt = r_count + 1'b1;
            2'b01:   w_count_nxt = r_count - 1'b1;
            default: w_count_nxt = r_count;
        endcase
    end

    // Storage array, written at the tail.
    always_ff @(posedge clk) begin
        if (w_push) r_mem[r_wr_ptr] <= i_data;
    end

    // Pointers, occupancy flags and sticky overflow.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_count    <= '0;
            r_full     <= 1'b0;
            r_empty    <= 1'b1;
            r_overflow <= 1'b0;
        end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
            r_count <= w_count_nxt;
            r_full  <= (w_count_nxt == CW'(DEPTH));
            r_empty <= (w_count_nxt == '0);
            if (i_push && r_full) r_overflow <= 1'b1;
        end
    end

    assign o_head     = r_mem[r_rd_ptr];
    assign o_empty    = r_empty;
    assign o_full     = r_full;
    assign o_count    = r_count;
    assign o_overflow = r_overflow;

endmodule

// File: rtl/spiroc_readout_emulator.sv
// SPIROC2b serial readout port model: queued words go out MSB first on an
// active-low DOUT/TRANSMIT_ON pair, each frame closed by an END_READOUT pulse.
module spiroc_readout_emulator
    import spiroc_emu_pkg::*;
#(
    parameter int WORD_W     = WORD_W_DEF,
    parameter int FIFO_DEPTH = 64,
    parameter int BIT_DIV    = 8,
    parameter int END_PULSE  = 8
) (
    input  logic clk,
    input  logic rst,
    spiroc_readout_emulator_if.slave bus
);

    localparam int CNT_W = CLOG2(FIFO_DEPTH) + 1;
    localparam int DIV_W = CTR_W(BIT_DIV);
    localparam int BIT_W = CTR_W(WORD_W);
    localparam int END_W = CTR_W(END_PULSE);

    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(BIT_DIV - 1);
    localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(WORD_W - 1);
    localparam logic [END_W-1:0] END_LAST = END_W'(END_PULSE - 1);

    localparam logic [1:0] S_IDLE  = ST_IDLE;
    localparam logic [1:0] S_SHIFT = ST_SHIFT;
    localparam logic [1:0] S_END   = ST_END;

    logic              r_start;
    logic              r_start_prev;
    logic [1:0]        r_state;
    logic [WORD_W-1:0] r_shreg;
    logic [DIV_W-1:0]  r_div_cnt;
    logic [BIT_W-1:0]  r_bit_cnt;
    logic [END_W-1:0]  r_end_cnt;
    logic              r_dout_b;
    logic              r_tx_on_b;
    logic              r_end_readout;
    logic              r_busy;

    logic              w_rise;
    logic              w_bit_last;
    logic              w_word_last;
    logic [1:0]        w_state_nxt;
    logic [WORD_W-1:0] w_shreg_nxt;
    logic [DIV_W-1:0]  w_div_nxt;
    logic [BIT_W-1:0]  w_bit_nxt;
    logic [END_W-1:0]  w_end_nxt;
    logic              w_pop;
    logic [WORD_W-1:0] w_head;
    logic              w_empty;
    logic              w_full;
    logic [CNT_W-1:0]  w_count;
    logic              w_overflow;

    emu_word_fifo #(
        .WORD_W (WORD_W),
        .DEPTH  (FIFO_DEPTH)
    ) u_fifo (
        .clk        (clk),
        .rst        (rst),
        .i_push     (bus.wr_en),
        .i_data     (bus.wr_data),
        .i_pop      (w_pop),
        .o_head     (w_head),
        .o_empty    (w_empty),
        .o_full     (w_full),
        .o_count    (w_count),
        .o_overflow (w_overflow)
    );

    // Request synchroniser/edge detector; a level already high across reset is not a rise.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_start      <= bus.start_readout;
            r_start_prev <= 1'b1;
        end else begin
            r_start      <= bus.start_readout;
            r_start_prev <= r_start;
        end
    end

    assign w_rise      = r_start & ~r_start_prev;
    assign w_bit_last  = (r_div_cnt == DIV_LAST);
    assign w_word_last = w_bit_last && (r_bit_cnt == BIT_LAST);

    // Next-state logic for the frame FSM, shifter and bit/divider counters.
    always_comb begin
        w_state_nxt = r_state;
        w_shreg_nxt = r_shreg;
        w_div_nxt   = r_div_cnt;
        w_bit_nxt   = r_bit_cnt;
        w_end_nxt   = r_end_cnt;
        w_pop       = 1'b0;
        case (r_state)
            S_IDLE: begin
                w_end_nxt = '0;
                if (w_rise) begin
                    if (!w_empty) begin
                        w_shreg_nxt = w_head;
                        w_pop       = 1'b1;
                        w_div_nxt   = '0;
                        w_bit_nxt   = '0;
                        w_state_nxt = S_SHIFT;
                    end else begin
                        w_state_nxt = S_END;
                    end
                end
            end
            S_SHIFT: begin
                if (w_bit_last) begin
                    w_div_nxt = '0;
                    if (w_word_last) begin
                        w_bit_nxt = '0;
                        // Chain the next word without a gap only while the request is still held.
                        if (!w_empty && r_start) begin
                            w_shreg_nxt = w_head;
                            w_pop       = 1'b1;
                        end else begin
                            w_end_nxt   = '0;
                            w_state_nxt = S_END;
                        end
                    end else begin
                        w_shreg_nxt = {r_shreg[WORD_W-2:0], 1'b0};
                        w_bit_nxt   = r_bit_cnt + 1'b1;
                    end
                end else begin
                    w_div_nxt = r_div_cnt + 1'b1;
                end
            end
            S_END: begin
                if (r_end_cnt == END_LAST) begin
                    w_state_nxt = S_IDLE;
                end else begin
                    w_end_nxt = r_end_cnt + 1'b1;
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // State, datapath and output registers; outputs decode the next state so they align with it.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state       <= S_IDLE;
            r_shreg       <= '0;
            r_div_cnt     <= '0;
            r_bit_cnt     <= '0;
            r_end_cnt     <= '0;
            r_dout_b      <= 1'b1;
            r_tx_on_b     <= 1'b1;
            r_end_readout <= 1'b0;
            r_busy        <= 1'b0;
        end else begin
            r_state       <= w_state_nxt;
            r_shreg       <= w_shreg_nxt;
            r_div_cnt     <= w_div_nxt;
            r_bit_cnt     <= w_bit_nxt;
            r_end_cnt     <= w_end_nxt;
            r_dout_b      <= (w_state_nxt == S_SHIFT) ? ~w_shreg_nxt[WORD_W-1] : 1'b1;
            r_tx_on_b     <= (w_state_nxt != S_SHIFT);
            r_end_readout <= (w_state_nxt == S_END);
            r_busy        <= (w_state_nxt != S_IDLE);
        end
    end

    assign bus.full          = w_full;
    assign bus.count         = w_count;
    assign bus.overflow      = w_overflow;
    assign bus.dout_b        = r_dout_b;
    assign bus.transmit_on_b = r_tx_on_b;
    assign bus.end_readout   = r_end_readout;
    assign bus.busy          = r_busy;
    assign bus.dbg_state     = r_state;

endmodule
